// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue and its consumer.
// Latency: none (declarations only).
// Backpressure: n/a.
package inst_fetch_queue_pkg;

    localparam int INST_W = 8;

    // Instruction field positions as seen by the downstream pipeline.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [1:0] inst_opcode(input logic [INST_W-1:0] i);
        return i[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundles the imem request/response port and the instruction issue port.
// Latency: none (wires only).
// Backpressure: imem_req_ready stalls requests, inst_ready stalls issue.
interface inst_fetch_queue_if #(
    parameter int PC_W = 8
);
    import inst_fetch_queue_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// Generic synchronous FIFO holding {instruction, pc} entries with a clear input.
// Latency: push at edge N is visible at the head from cycle N+1; no bypass.
// Backpressure: pushes into a full FIFO and pops from an empty one are ignored.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    input  logic         clr,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop   = pop && (count != '0) && !clr;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop) && !clr;
    assign head_vld = (count != '0);
    // Head reads as zero when empty so consumers never see stale entries.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    // Pointers and fill count; clear empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: generates PCs, fetches one instruction at a time from imem, queues them for issue.
// Latency: response at edge N appears on inst from cycle N+1; one instruction per 2 cycles at best.
// Backpressure: requests are only issued while the FIFO has a free slot, so responses always fit.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic                   flush,
    input  logic [PC_W-1:0]        redirect_pc,
    inst_fetch_queue_if.master     bus,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + PC_W;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] req_pc;
    logic            drop;
    logic            drop_nxt;
    logic            req_hs;
    logic            rsp_in_wait;
    logic            push;
    logic            pop;
    logic            in_flight;
    logic [CW-1:0]   occ_after;
    logic [EW-1:0]   head_dat;

    assign req_hs      = (state == REQ) && bus.imem_req_ready;
    assign rsp_in_wait = (state == WAIT) && bus.imem_rsp_valid;
    // A flush discards whatever is at the head, so the pop is suppressed.
    assign pop         = bus.inst_valid && bus.inst_ready && !flush;
    assign push        = rsp_in_wait && !drop && !flush;
    assign occ_after   = occupancy + CW'(push) - CW'(pop);
    // A request is outstanding after this edge if we are waiting and nothing came back, or one launches now.
    assign in_flight   = (rsp_in_wait == 1'b0 && state == WAIT) || req_hs;

    assign bus.imem_req_valid = (state == REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst           = head_dat[EW-1:PC_W];
    assign bus.inst_pc        = head_dat[PC_W-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({bus.imem_rsp_data, req_pc}),
        .pop      (pop),
        .clr      (flush),
        .head_vld (bus.inst_valid),
        .head_dat (head_dat),
        .count    (occupancy)
    );

    // State, PC and stale-response flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            drop   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            drop  <= drop_nxt;
            if (req_hs) req_pc <= pc;
        end
    end

    // Next-state logic; flush overrides the normal transitions.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        case (state)
            IDLE: begin
                if (fetch_en && (occupancy < CW'(DEPTH))) state_nxt = REQ;
            end
            REQ: begin
                if (req_hs) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = WAIT;
                end else if (!fetch_en) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    drop_nxt  = 1'b0;
                    state_nxt = (fetch_en && (occ_after < CW'(DEPTH))) ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            pc_nxt   = redirect_pc;
            drop_nxt = in_flight;
            // With a stale response still due we keep waiting for it before issuing again.
            if (in_flight)     state_nxt = WAIT;
            else if (fetch_en) state_nxt = REQ;
            else               state_nxt = IDLE;
        end
    end

endmodule
